pifo_dequeue_drain: RTL and testbench
=====================================

// Module: pifo_dequeue_drain
// PURPOSE
//  Dequeue-side controller for flow_pifo. Pops the PIFO head whenever buffer space, pacing and enable allow.
//  Each popped (priority, packet pointer) pair goes into a 2-entry output buffer.
//  The buffer presents the pairs downstream (egress / packet-buffer reader) on a valid/ready interface.
//  Decouples downstream backpressure from the PIFO pop path and enforces a programmable minimum dequeue gap.
// PARAMETERS
//  PRIO_WIDTH   16  width of Priority
//  PTR_WIDTH    16  width of PacketPointer
//  GAP_WIDTH    8   width of pacing gap register
//  CNT_WIDTH    32  width of dequeue statistics counter
// PORTS
//  clk                 in   1           clock
//  reset               in   1           asynchronous, active-low reset
//  i__enable           in   1           1 = permit new pops
//  i__gap              in   GAP_WIDTH   idle cycles required after each pop (0 = back-to-back)
//  i__pifo_empty       in   1           flow_pifo o__pifo_empty
//  i__pifo_priority    in   PRIO_WIDTH  flow_pifo o__dequeue_priority (head, combinational)
//  i__pifo_pointer     in   PTR_WIDTH   flow_pifo o__packet_pointer (head, combinational)
//  o__pifo_dequeue     out  1           to flow_pifo i__dequeue; pop at rising edge
//  o__out_valid        out  1           output buffer head valid
//  o__out_priority     out  PRIO_WIDTH  head priority
//  o__out_pointer      out  PTR_WIDTH   head packet pointer
//  i__out_ready        in   1           downstream accepts head this cycle
//  o__dequeue_count    out  CNT_WIDTH   total pops since reset
//  o__idle             out  1           nothing buffered, no pacing pending, nothing poppable
// BEHAVIOUR
//  Reset (reset==0, async): buffer count=0, gap_cnt=0, dequeue_count=0.
//   All registered outputs are 0. o__pifo_dequeue is forced 0 while reset==0.
//  Buffer: 2-entry FIFO, registered outputs; out pair = entry at read pointer.
//   count in {0,1,2}. pop_out = o__out_valid & i__out_ready.
//   space = (count<2) | pop_out, so a full buffer with the head leaving accepts a new entry in the same cycle.
//  Pop: o__pifo_dequeue = enable & ~i__pifo_empty & space & (gap_cnt==0) & reset.
//   Combinational, no registers on the path.
//   On the same edge, capture i__pifo_priority / i__pifo_pointer into the write slot.
//  Latency: pop at edge of cycle t -> o__out_valid=1 with that pair in cycle t+1 when the buffer was empty.
//   No bypass from PIFO to the output ports.
//  Ordering: strict FIFO. Downstream sees pairs in PIFO pop order.
//  Simultaneous push and pop_out: count is unchanged; both pointers advance (1-bit, wrap 1->0).
//  Pacing: on pop, gap_cnt <= i__gap. Else if gap_cnt!=0, gap_cnt <= gap_cnt-1.
//   With i__gap=g, successive pops are >= g+1 cycles apart.
//   i__gap is sampled only at pop time.
//  Enable: i__enable=0 blocks new pops only. Buffered entries still drain; gap_cnt keeps counting down.
//  Counter: dequeue_count += 1 per pop, wraps modulo 2^CNT_WIDTH.
//  Idle: o__idle = (count==0) & (gap_cnt==0) & (i__pifo_empty | ~i__enable). Combinational.
//  Handshake: o__out_valid/o__out_priority/o__out_pointer stay stable while valid & ~ready.
//   i__out_ready with valid=0 is ignored.
//  Reset mid-operation: buffered pairs are discarded (already popped from flow_pifo, not reinserted).
//   Upstream must reset flow_pifo with it.
//  Any pop while count==2 & ~pop_out is impossible by construction; assert it never occurs.
// TESTING
//  T1 reset: hold reset=0 with pifo non-empty, enable=1 -> o__pifo_dequeue=0, out_valid=0, count=0.
//   Release -> first pop next edge.
//  T2 streaming: PIFO holds prio {3,5,9} ptr {10,11,12}, gap=0, ready=1.
//   -> pops on 3 consecutive cycles; out pairs (3,10),(5,11),(9,12) on t+1..t+3; dequeue_count=3.
//  T3 backpressure: 5 entries, ready=0 -> exactly 2 pops, then dequeue=0, out holds (first pair).
//   Ready=1 for 1 cycle -> exactly 1 more pop in that cycle.
//  T4 pacing: gap=3, 3 entries, ready=1 -> pops at cycles t, t+4, t+8.
//   Gap changed to 0 after first pop -> second pop still at t+4.
//  T5 enable: drop enable with 2 buffered, PIFO non-empty -> no pops; both entries drain.
//   o__idle=1 only after drain and gap_cnt==0.
//  T6 reset mid-run: assert reset with count=2 -> out_valid=0 immediately (async); dequeue_count=0.

Source files
------------

// File: rtl/pifo_dequeue_drain.sv
// pifo_dequeue_drain
//   Dequeue-side controller for flow_pifo. Pops the PIFO head whenever the
//   2-entry output buffer has room, the pacing gap has elapsed and popping is
//   enabled. Popped (priority, pointer) pairs are presented downstream on a
//   valid/ready interface in strict pop order.
//
// Ports
//   clk               clock
//   reset             asynchronous active-low reset
//   i__enable         1 = permit new pops (buffered entries drain regardless)
//   i__gap            idle cycles required after each pop, sampled at pop time
//   i__pifo_empty     flow_pifo empty flag
//   i__pifo_priority  flow_pifo head priority (combinational)
//   i__pifo_pointer   flow_pifo head packet pointer (combinational)
//   o__pifo_dequeue   pop strobe to flow_pifo, pop happens at the rising edge
//   o__out_valid      output buffer head valid
//   o__out_priority   output buffer head priority
//   o__out_pointer    output buffer head packet pointer
//   i__out_ready      downstream accepts the head this cycle
//   o__dequeue_count  total pops since reset (wraps)
//   o__idle           nothing buffered, no pacing pending, nothing poppable
module pifo_dequeue_drain #(
  parameter int unsigned PRIO_WIDTH = 16,
  parameter int unsigned PTR_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH  = 8,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i__enable,
  input  logic [GAP_WIDTH-1:0]  i__gap,
  input  logic                  i__pifo_empty,
  input  logic [PRIO_WIDTH-1:0] i__pifo_priority,
  input  logic [PTR_WIDTH-1:0]  i__pifo_pointer,
  output logic                  o__pifo_dequeue,
  output logic                  o__out_valid,
  output logic [PRIO_WIDTH-1:0] o__out_priority,
  output logic [PTR_WIDTH-1:0]  o__out_pointer,
  input  logic                  i__out_ready,
  output logic [CNT_WIDTH-1:0]  o__dequeue_count,
  output logic                  o__idle
);

  logic [PRIO_WIDTH-1:0] buf_prio [2];
  logic [PTR_WIDTH-1:0]  buf_ptr  [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [GAP_WIDTH-1:0]  gap_cnt;
  logic [CNT_WIDTH-1:0]  deq_cnt;

  logic pop_out;
  logic space;
  logic pop;

  // A full buffer whose head leaves this cycle can take a new entry on the
  // same edge, so back-to-back streaming needs only two slots.
  always_comb begin
    pop_out = (count != 2'd0) & i__out_ready;
    space   = (count != 2'd2) | pop_out;
    pop     = i__enable & ~i__pifo_empty & space & (gap_cnt == '0) & reset;
  end

  assign o__pifo_dequeue  = pop;
  assign o__out_valid     = (count != 2'd0);
  assign o__out_priority  = buf_prio[rd_ptr];
  assign o__out_pointer   = buf_ptr[rd_ptr];
  assign o__dequeue_count = deq_cnt;
  assign o__idle          = (count == 2'd0) & (gap_cnt == '0) &
                            (i__pifo_empty | ~i__enable);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_prio[0] <= '0;
      buf_prio[1] <= '0;
      buf_ptr[0]  <= '0;
      buf_ptr[1]  <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= '0;
      gap_cnt     <= '0;
      deq_cnt     <= '0;
    end else begin
      if (pop) begin
        buf_prio[wr_ptr] <= i__pifo_priority;
        buf_ptr[wr_ptr]  <= i__pifo_pointer;
        wr_ptr           <= ~wr_ptr;
        deq_cnt          <= deq_cnt + CNT_WIDTH'(1);
        gap_cnt          <= i__gap;
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
      end

      if (pop_out) begin
        rd_ptr <= ~rd_ptr;
      end

      case ({pop, pop_out})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Overflow cannot happen because pop already requires space.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!(pop && (count == 2'd2) && !pop_out));
    end
  end

endmodule

// File: tb/tb_pifo_dequeue_drain.sv
module tb_pifo_dequeue_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        i__enable;
  logic [7:0]  i__gap;
  logic        i__pifo_empty;
  logic [15:0] i__pifo_priority;
  logic [15:0] i__pifo_pointer;
  logic        o__pifo_dequeue;
  logic        o__out_valid;
  logic [15:0] o__out_priority;
  logic [15:0] o__out_pointer;
  logic        i__out_ready;
  logic [31:0] o__dequeue_count;
  logic        o__idle;

  pifo_dequeue_drain #(
    .PRIO_WIDTH(16),
    .PTR_WIDTH (16),
    .GAP_WIDTH (8),
    .CNT_WIDTH (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .i__enable        (i__enable),
    .i__gap           (i__gap),
    .i__pifo_empty    (i__pifo_empty),
    .i__pifo_priority (i__pifo_priority),
    .i__pifo_pointer  (i__pifo_pointer),
    .o__pifo_dequeue  (o__pifo_dequeue),
    .o__out_valid     (o__out_valid),
    .o__out_priority  (o__out_priority),
    .o__out_pointer   (o__out_pointer),
    .i__out_ready     (i__out_ready),
    .o__dequeue_count (o__dequeue_count),
    .o__idle          (o__idle)
  );

  always #5 clk = ~clk;

  // Reference model: PIFO contents (kept sorted by priority), output buffer
  // contents, pop history for pacing, and total pop count.
  logic [15:0] pq_prio [$];
  logic [15:0] pq_ptr  [$];
  logic [15:0] bq_prio [$];
  logic [15:0] bq_ptr  [$];
  int          cyc;
  int          last_pop;
  int          last_gap;
  logic [31:0] m_count;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pifo_push(input logic [15:0] p, input logic [15:0] ptr);
    int idx;
    idx = pq_prio.size();
    for (int i = 0; i < pq_prio.size(); i++) begin
      if (pq_prio[i] > p) begin
        idx = i;
        break;
      end
    end
    pq_prio.insert(idx, p);
    pq_ptr.insert(idx, ptr);
  endtask

  task automatic drive_heads();
    i__pifo_empty    = (pq_prio.size() == 0);
    i__pifo_priority = (pq_prio.size() != 0) ? pq_prio[0] : 16'h0;
    i__pifo_pointer  = (pq_ptr.size() != 0) ? pq_ptr[0] : 16'h0;
  endtask

  task automatic model_clear();
    bq_prio.delete();
    bq_ptr.delete();
    m_count  = '0;
    last_pop = -1000;
    last_gap = 0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model on
  // the rising edge using the decisions taken from the model.
  task automatic step();
    bit sp, gap_ok, e_pop, e_po, e_idle;
    drive_heads();
    @(negedge clk);
    sp     = (bq_prio.size() < 2) || ((bq_prio.size() > 0) && i__out_ready);
    gap_ok = (cyc - last_pop) > last_gap;
    e_pop  = i__enable && (pq_prio.size() > 0) && sp && gap_ok && (reset === 1'b1);
    e_po   = (bq_prio.size() > 0) && i__out_ready;
    e_idle = (bq_prio.size() == 0) && gap_ok && ((pq_prio.size() == 0) || !i__enable);
    chk("pifo_dequeue", o__pifo_dequeue, e_pop);
    chk("out_valid", o__out_valid, bq_prio.size() > 0);
    if (bq_prio.size() > 0) begin
      chk("out_priority", o__out_priority, bq_prio[0]);
      chk("out_pointer", o__out_pointer, bq_ptr[0]);
    end
    chk("dequeue_count", o__dequeue_count, m_count);
    chk("idle", o__idle, e_idle);
    @(posedge clk);
    if (reset === 1'b1) begin
      if (e_po) begin
        void'(bq_prio.pop_front());
        void'(bq_ptr.pop_front());
      end
      if (e_pop) begin
        bq_prio.push_back(pq_prio.pop_front());
        bq_ptr.push_back(pq_ptr.pop_front());
        m_count++;
        last_pop = cyc;
        last_gap = int'(i__gap);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    pq_prio.delete();
    pq_ptr.delete();
    reset = 1'b0;
    model_clear();
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset        = 1'b0;
    i__enable    = 1'b1;
    i__gap       = 8'd0;
    i__out_ready = 1'b0;
    cyc          = 0;
    model_clear();
    drive_heads();

    // T1: reset held with a non-empty PIFO and enable high
    pifo_push(16'd7, 16'd70);
    pifo_push(16'd8, 16'd80);
    step();
    step();
    chk("t1_dequeue_in_reset", o__pifo_dequeue, 1'b0);
    reset = 1'b1;
    step();
    chk("t1_first_pop_count", o__dequeue_count, 32'd1);
    chk("t1_first_valid", o__out_valid, 1'b1);
    chk("t1_first_prio", o__out_priority, 16'd7);

    // T2: streaming with gap 0 and ready high
    do_reset();
    i__out_ready = 1'b1;
    pifo_push(16'd3, 16'd10);
    pifo_push(16'd5, 16'd11);
    pifo_push(16'd9, 16'd12);
    for (int i = 0; i < 6; i++) step();
    chk("t2_count", o__dequeue_count, 32'd3);

    // T3: backpressure with 5 entries
    do_reset();
    i__out_ready = 1'b0;
    for (int i = 0; i < 5; i++) pifo_push(16'(20 + i), 16'(100 + i));
    for (int i = 0; i < 6; i++) step();
    chk("t3_stall_count", o__dequeue_count, 32'd2);
    chk("t3_head_prio", o__out_priority, 16'd20);
    chk("t3_head_ptr", o__out_pointer, 16'd100);
    i__out_ready = 1'b1;
    step();
    i__out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t3_one_more", o__dequeue_count, 32'd3);
    chk("t3_head_after", o__out_priority, 16'd21);

    // T4: pacing gap 3, gap changed to 0 after the first pop
    do_reset();
    i__out_ready = 1'b1;
    i__gap       = 8'd3;
    for (int i = 0; i < 3; i++) pifo_push(16'(40 + i), 16'(200 + i));
    step();
    chk("t4_first", o__dequeue_count, 32'd1);
    i__gap = 8'd0;
    for (int i = 0; i < 3; i++) step();
    chk("t4_still_paced", o__dequeue_count, 32'd1);
    step();
    chk("t4_second_at_4", o__dequeue_count, 32'd2);
    for (int i = 0; i < 4; i++) step();
    chk("t4_third", o__dequeue_count, 32'd3);

    // T5: drop enable with 2 buffered and the PIFO still non-empty
    do_reset();
    i__out_ready = 1'b0;
    i__gap       = 8'd2;
    for (int i = 0; i < 4; i++) pifo_push(16'(60 + i), 16'(300 + i));
    for (int i = 0; i < 8; i++) step();
    chk("t5_buffered", o__dequeue_count, 32'd2);
    i__enable    = 1'b0;
    i__out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("t5_no_pops", o__dequeue_count, 32'd2);
    chk("t5_drained", o__out_valid, 1'b0);
    chk("t5_idle", o__idle, 1'b1);
    i__enable = 1'b1;
    i__gap    = 8'd0;

    // T6: asynchronous reset with a full buffer
    i__out_ready = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("t6_full_valid", o__out_valid, 1'b1);
    #2;
    reset = 1'b0;
    model_clear();
    pq_prio.delete();
    pq_ptr.delete();
    drive_heads();
    #1;
    chk("t6_async_valid", o__out_valid, 1'b0);
    chk("t6_async_count", o__dequeue_count, 32'd0);
    chk("t6_async_dequeue", o__pifo_dequeue, 1'b0);
    step();
    reset = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      i__out_ready = ($urandom % 4) != 0;
      i__enable    = ($urandom % 8) != 0;
      if (($urandom % 8) == 0) i__gap = 8'($urandom % 4);
      if ((($urandom % 3) == 0) && (pq_prio.size() < 8))
        pifo_push(16'($urandom % 64), 16'($urandom));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
